// File: rtl/mp_fifo_pkg.sv
// Shared FIFO width helpers and the protocol-error cause encoding used by the
// completion/retire tracker.
package mp_fifo_pkg;

    typedef enum logic [1:0] {
        ALLOC_DUP   = 2'd0,
        CPL_UNALLOC = 2'd1,
        CPL_DUP     = 2'd2
    } err_cause_e;

    localparam int ERR_CAUSE_N = 3;

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/one_counter.sv
// Combinational popcount of a strobe vector.
module one_counter
    import mp_fifo_pkg::*;
#(
    parameter int W     = 4,
    parameter int OUT_W = fifo_cnt_w(W)
) (
    input  logic [W-1:0]     vec_i,
    output logic [OUT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + OUT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/mp_fifo_cpl_retire.sv
// Tracks allocate/complete state per FIFO entry and grants in-order retirement
// of the FIFO head entries once they have completed.
module mp_fifo_cpl_retire
    import mp_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ALLOC_WIDTH  = 4,
    parameter int CPL_WIDTH    = 2,
    parameter int RETIRE_WIDTH = 4,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ALLOC_WIDTH-1:0]             alloc_vld_i,
    input  logic [ALLOC_WIDTH-1:0][PTR_W-1:0]  alloc_ptr_i,
    input  logic [CPL_WIDTH-1:0]               cpl_vld_i,
    input  logic [CPL_WIDTH-1:0][PTR_W-1:0]    cpl_ptr_i,
    input  logic [RETIRE_WIDTH-1:0]            head_vld_i,
    input  logic [RETIRE_WIDTH-1:0][PTR_W-1:0] head_ptr_i,
    input  logic                               retire_en_i,
    output logic [RETIRE_WIDTH-1:0]            retire_rdy_o,
    output logic [CNT_W-1:0]                   retire_cnt_o,
    output logic [CNT_W-1:0]                   pending_cnt_o,
    input  logic                               flush_i,
    output logic                               err_o
);

    logic [DEPTH-1:0]        alloc_q, alloc_d;
    logic [DEPTH-1:0]        done_q, done_d;
    logic [CNT_W-1:0]        pending_q, pending_d;
    logic                    err_q, err_d;

    logic [RETIRE_WIDTH-1:0] fire;
    logic [DEPTH-1:0]        retiring;
    logic [CPL_WIDTH-1:0]    cpl_ok;
    logic [ERR_CAUSE_N-1:0]  cause;
    logic [CNT_W-1:0]        n_alloc, n_cpl, n_ret;
    logic [CNT_W:0]          pend_sum;
    logic                    chain;
    logic                    dup;

    // Readiness is a prefix chain so retirement can never skip an entry.
    always_comb begin
        retire_rdy_o = '0;
        chain        = retire_en_i;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            chain           = chain & head_vld_i[i] & done_q[head_ptr_i[i]];
            retire_rdy_o[i] = chain;
        end
    end

    assign fire = retire_rdy_o & head_vld_i;

    one_counter #(.W(ALLOC_WIDTH),  .OUT_W(CNT_W)) u_cnt_alloc (.vec_i(alloc_vld_i), .cnt_o(n_alloc));
    one_counter #(.W(CPL_WIDTH),    .OUT_W(CNT_W)) u_cnt_cpl   (.vec_i(cpl_ok),      .cnt_o(n_cpl));
    one_counter #(.W(RETIRE_WIDTH), .OUT_W(CNT_W)) u_cnt_ret   (.vec_i(fire),        .cnt_o(n_ret));

    assign retire_cnt_o = n_ret;

    always_comb begin
        retiring = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (fire[i]) retiring[head_ptr_i[i]] = 1'b1;
        end

        // A completion counts once per distinct entry; the first port carrying a pointer wins.
        cpl_ok = '0;
        cause  = '0;
        dup    = 1'b0;
        for (int j = 0; j < CPL_WIDTH; j++) begin
            if (cpl_vld_i[j]) begin
                if (!alloc_q[cpl_ptr_i[j]]) begin
                    cause[CPL_UNALLOC] = 1'b1;
                end else if (done_q[cpl_ptr_i[j]]) begin
                    cause[CPL_DUP] = 1'b1;
                end else begin
                    dup = 1'b0;
                    for (int jj = 0; jj < j; jj++) begin
                        if (cpl_vld_i[jj] && (cpl_ptr_i[jj] == cpl_ptr_i[j])) dup = 1'b1;
                    end
                    cpl_ok[j] = ~dup;
                end
            end
        end

        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (alloc_vld_i[k] && alloc_q[alloc_ptr_i[k]] && !retiring[alloc_ptr_i[k]]) begin
                cause[ALLOC_DUP] = 1'b1;
            end
        end

        // Alloc is applied last so it overrides a same-cycle retire of the entry.
        alloc_d = alloc_q & ~retiring;
        done_d  = done_q & ~retiring;
        for (int j = 0; j < CPL_WIDTH; j++) begin
            if (cpl_ok[j]) done_d[cpl_ptr_i[j]] = 1'b1;
        end
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (alloc_vld_i[k]) begin
                alloc_d[alloc_ptr_i[k]] = 1'b1;
                done_d[alloc_ptr_i[k]]  = 1'b0;
            end
        end

        pend_sum = {1'b0, pending_q} + {1'b0, n_alloc};
        if (pend_sum <= {1'b0, n_cpl}) begin
            pending_d = '0;
        end else begin
            pend_sum = pend_sum - {1'b0, n_cpl};
            if (pend_sum > (CNT_W+1)'(DEPTH)) pending_d = CNT_W'(DEPTH);
            else                              pending_d = pend_sum[CNT_W-1:0];
        end

        err_d = err_q | (|cause);

        if (flush_i) begin
            alloc_d   = '0;
            done_d    = '0;
            pending_d = '0;
            err_d     = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q   <= '0;
            done_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            alloc_q   <= alloc_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_cnt_o = pending_q;
    assign err_o         = err_q;

endmodule
